// File: rtl/ara_exit_monitor_if.sv
// Bundle between ara_soc's exit port and the exit monitor: exit word in, LED/status out.
// The monitor is the slave; whatever drives exit_i (the soc, or a bench) is the master.
interface ara_exit_monitor_if;
    logic [63:0] exit_i;
    logic [7:0]  leds_o;
    logic        done_o;
    logic        pass_o;
    logic [62:0] exit_code_o;

    modport master (
        output exit_i,
        input  leds_o,
        input  done_o,
        input  pass_o,
        input  exit_code_o
    );

    modport slave (
        input  exit_i,
        output leds_o,
        output done_o,
        output pass_o,
        output exit_code_o
    );
endinterface

// File: rtl/ara_exit_monitor.sv
// riscv-tests exit-word monitor: latches pass/fail + code and drives board LEDs.
// Optional ARA_EXIT_MONITOR_STABLE_EN requires StableCycles identical samples before latching.
module ara_exit_monitor #(
    parameter int          HalfPeriodCycles = 25_000_000,
    parameter logic [7:0]  PassPattern      = 8'hA5,
    parameter int          StableCycles     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ara_exit_monitor_if.slave mon
);

    localparam int CNT_W = $clog2(HalfPeriodCycles);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(HalfPeriodCycles - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (HalfPeriodCycles < 2) begin : g_bad_half_period
        $error("HalfPeriodCycles must be >= 2");
    end
    if (StableCycles < 1) begin : g_bad_stable_cycles
        $error("StableCycles must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              phase_r, phase_s;
    logic [7:0]        leds_r, leds_s;
    logic              done_r, done_s;
    logic              pass_r, pass_s;
    logic [62:0]       code_r, code_s;
    logic              event_s;
    logic              tick_s;

`ifdef ARA_EXIT_MONITOR_STABLE_EN
    localparam int SW = $clog2(StableCycles + 1);

    logic [63:0]   prev_r;
    logic [SW-1:0] stab_r, stab_s;
    int            run_s;

    // run_s is the zero-based position of the current sample in a run of identical valid samples
    always_comb begin
        run_s   = 0;
        stab_s  = '0;
        event_s = 1'b0;
        if (mon.exit_i[0] && (mon.exit_i == prev_r)) begin
            run_s = int'(stab_r) + 1;
        end else begin
            run_s = 0;
        end
        if (run_s >= StableCycles) begin
            stab_s = SW'(StableCycles);
        end else begin
            stab_s = SW'(run_s);
        end
        event_s = mon.exit_i[0] && (run_s == StableCycles - 1);
    end

    // Previous-sample and stability-count registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_r <= 64'h0;
            stab_r <= '0;
        end else begin
            prev_r <= mon.exit_i;
            stab_r <= stab_s;
        end
    end
`else
    assign event_s = mon.exit_i[0];
`endif

    assign tick_s = (cnt_r == CNT_TERM);

    // Next-state and next-output logic; LEDs follow the state being entered on the same edge
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        phase_s = phase_r;
        leds_s  = leds_r;
        done_s  = done_r;
        pass_s  = pass_r;
        code_s  = code_r;
        case (state_r)
            ST_RUN: begin
                if (tick_s) begin
                    cnt_s   = '0;
                    phase_s = ~phase_r;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
                leds_s = {7'b000_0000, phase_s};
                if (event_s) begin
                    done_s = 1'b1;
                    code_s = mon.exit_i[63:1];
                    cnt_s  = '0;
                    if (mon.exit_i[63:1] == 63'd0) begin
                        pass_s  = 1'b1;
                        state_s = ST_PASS;
                        leds_s  = PassPattern;
                    end else begin
                        state_s = ST_FAIL;
                        phase_s = 1'b1;
                        leds_s  = {1'b1, mon.exit_i[7:1]};
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PASS: begin
                cnt_s  = '0;
                leds_s = PassPattern;
            end
            ST_FAIL: begin
                if (tick_s) begin
                    cnt_s   = '0;
                    phase_s = ~phase_r;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
                leds_s = phase_s ? {1'b1, code_r[6:0]} : 8'h00;
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = '0;
                phase_s = 1'b0;
                leds_s  = 8'h00;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
            phase_r <= 1'b0;
            leds_r  <= 8'h00;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            code_r  <= 63'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            phase_r <= phase_s;
            leds_r  <= leds_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
            code_r  <= code_s;
        end
    end

    assign mon.leds_o      = leds_r;
    assign mon.done_o      = done_r;
    assign mon.pass_o      = pass_r;
    assign mon.exit_code_o = code_r;

endmodule

// File: tb/tb_ara_exit_monitor.sv
// Bench for ara_exit_monitor: run-length/elapsed-time model checked every cycle,
// plus literal expectations at the points the test plan calls out.
module tb_ara_exit_monitor;

    localparam int HALF = 4;
`ifdef ARA_EXIT_MONITOR_STABLE_EN
    localparam int STABLE = 3;
`else
    localparam int STABLE = 1;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    bit   chk_en;

    ara_exit_monitor_if ifc ();

    ara_exit_monitor #(
        .HalfPeriodCycles (HALF),
        .PassPattern      (8'hA5),
        .StableCycles     (3)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .mon   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0=running, 1=passed, 2=failed; elapsed-edge counters drive the LED expectation
    int          m_mode;
    int          m_run_edges;
    int          m_fail_edges;
    bit          m_done;
    bit          m_pass;
    logic [62:0] m_code;
    logic [63:0] m_prev;
    int          m_run_len;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_run_edges = 0; m_fail_edges = 0;
            m_done = 1'b0; m_pass = 1'b0; m_code = 63'd0;
            m_prev = 64'd0; m_run_len = 0;
        end else begin
            int len;
            if (ifc.exit_i[0] == 1'b0) len = 0;
            else if (ifc.exit_i == m_prev) len = m_run_len + 1;
            else len = 1;
            m_run_len = len;
            m_prev = ifc.exit_i;
            if (m_mode == 0) begin
                if (len >= STABLE) begin
                    m_done = 1'b1;
                    m_code = ifc.exit_i[63:1];
                    m_pass = (ifc.exit_i[63:1] == 63'd0);
                    m_mode = m_pass ? 1 : 2;
                    m_fail_edges = 0;
                end else begin
                    m_run_edges++;
                end
            end else if (m_mode == 2) begin
                m_fail_edges++;
            end
        end
    end

    function automatic logic [7:0] exp_leds();
        logic [7:0] v;
        if (m_mode == 0) v = ((m_run_edges / HALF) % 2 == 1) ? 8'h01 : 8'h00;
        else if (m_mode == 1) v = 8'hA5;
        else v = ((m_fail_edges / HALF) % 2 == 0) ? {1'b1, m_code[6:0]} : 8'h00;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_leds", {56'd0, ifc.leds_o}, {56'd0, exp_leds()});
            chk("model_done", {63'd0, ifc.done_o}, {63'd0, m_done});
            chk("model_pass", {63'd0, ifc.pass_o}, {63'd0, m_pass});
            chk("model_code", {1'b0, ifc.exit_code_o}, {1'b0, m_code});
        end
    end

    task automatic cyc(input logic [63:0] x, input logic r);
        ifc.exit_i = x;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [63:0] x, input int k);
        for (int i = 0; i < k; i++) cyc(x, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; chk_en = 1'b0;
        ifc.exit_i = 64'd0;
        rst = 1'b1;
        cyc(64'd0, 1'b1);
        cyc(64'd0, 1'b1);
        chk_en = 1'b1;
        chk("reset_leds", {56'd0, ifc.leds_o}, 64'h00);
        chk("reset_done", {63'd0, ifc.done_o}, 64'h0);

        // Heartbeat: 8'h01 first appears on the 4th edge after release
        for (int i = 1; i <= 20; i++) begin
            cyc(64'd0, 1'b0);
            if (i == 3) chk("hb_pre_rise", {56'd0, ifc.leds_o}, 64'h00);
            if (i == 4) chk("hb_first_rise", {56'd0, ifc.leds_o}, 64'h01);
            if (i == 8) chk("hb_fall", {56'd0, ifc.leds_o}, 64'h00);
        end
        chk("hb_done_low", {63'd0, ifc.done_o}, 64'h0);

        // Pass
        present(64'h1, STABLE);
        chk("pass_done", {63'd0, ifc.done_o}, 64'h1);
        chk("pass_pass", {63'd0, ifc.pass_o}, 64'h1);
        chk("pass_code", {1'b0, ifc.exit_code_o}, 64'h0);
        chk("pass_leds", {56'd0, ifc.leds_o}, 64'hA5);
        present(64'd0, 6);
        chk("pass_sticky", {56'd0, ifc.leds_o}, 64'hA5);

        // Fail with code 3, then reset mid-blink
        cyc(64'd0, 1'b1);
        present(64'd0, 2);
        present(64'h7, STABLE);
        chk("fail_done", {63'd0, ifc.done_o}, 64'h1);
        chk("fail_pass", {63'd0, ifc.pass_o}, 64'h0);
        chk("fail_code", {1'b0, ifc.exit_code_o}, 64'h3);
        chk("fail_leds_on", {56'd0, ifc.leds_o}, 64'h83);
        for (int k = 1; k <= 10; k++) begin
            cyc((k < 3) ? 64'h7 : 64'h0, 1'b0);
            if (k == 3) chk("fail_on_last", {56'd0, ifc.leds_o}, 64'h83);
            if (k == 4) chk("fail_off", {56'd0, ifc.leds_o}, 64'h00);
            if (k == 8) chk("fail_on_again", {56'd0, ifc.leds_o}, 64'h83);
        end
        cyc(64'd0, 1'b1);
        chk("rst_leds", {56'd0, ifc.leds_o}, 64'h00);
        chk("rst_done", {63'd0, ifc.done_o}, 64'h0);
        chk("rst_pass", {63'd0, ifc.pass_o}, 64'h0);
        chk("rst_code", {1'b0, ifc.exit_code_o}, 64'h0);
        for (int i = 1; i <= 4; i++) begin
            cyc(64'd0, 1'b0);
            if (i == 3) chk("hb2_pre_rise", {56'd0, ifc.leds_o}, 64'h00);
            if (i == 4) chk("hb2_rise", {56'd0, ifc.leds_o}, 64'h01);
        end

        // Filter sequence 0x5,0x5,0x9,0x9,0x9
        cyc(64'd0, 1'b1);
        cyc(64'h5, 1'b0);
`ifndef ARA_EXIT_MONITOR_STABLE_EN
        chk("seq_first_code", {1'b0, ifc.exit_code_o}, 64'h2);
        chk("seq_first_done", {63'd0, ifc.done_o}, 64'h1);
`endif
        cyc(64'h5, 1'b0);
        cyc(64'h9, 1'b0);
        cyc(64'h9, 1'b0);
`ifdef ARA_EXIT_MONITOR_STABLE_EN
        chk("seq_no_event_yet", {63'd0, ifc.done_o}, 64'h0);
`endif
        cyc(64'h9, 1'b0);
`ifdef ARA_EXIT_MONITOR_STABLE_EN
        chk("seq_done", {63'd0, ifc.done_o}, 64'h1);
        chk("seq_code", {1'b0, ifc.exit_code_o}, 64'h4);
        chk("seq_pass", {63'd0, ifc.pass_o}, 64'h0);
`endif
        present(64'd0, 3);

        // Top bit only: no event while bit0 is clear, then a wide code
        cyc(64'd0, 1'b1);
        present(64'h8000_0000_0000_0000, 5);
        chk("msb_no_event", {63'd0, ifc.done_o}, 64'h0);
        present(64'h8000_0000_0000_0001, STABLE);
        chk("msb_done", {63'd0, ifc.done_o}, 64'h1);
        chk("msb_code", {1'b0, ifc.exit_code_o}, 64'h4000_0000_0000_0000);
        chk("msb_leds_on", {56'd0, ifc.leds_o}, 64'h80);
        present(64'd0, 4);
        chk("msb_leds_off", {56'd0, ifc.leds_o}, 64'h00);
        present(64'd0, 4);
        chk("msb_leds_on2", {56'd0, ifc.leds_o}, 64'h80);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
